con_host_port: RTL and testbench
================================

# con_host_port

Host-side counterpart of the accelerator's three-bus connection interface. Streams activation/kernel triplets onto con_1..con_3 under the con_valid/con_ready handshake while the chip listens, and releases the bus and captures output triplets, with their x/y/ch tags, into a FIFO while the chip drives (driving_cons). It sits between the system stream and memory on one side and the accelerator's con pins on the other. Used as the synthesizable system model and as the basis of the board-level bridge.

## Interface
- IO_DATA_WIDTH, 16, width of each con bus.
- FEATURE_MAP_WIDTH, 1024, sets output_x width, $clog2.
- FEATURE_MAP_HEIGHT, 1024, sets output_y width, $clog2.
- OUTPUT_NB_CHANNELS, 64, sets output_ch width, $clog2.
- FIFO_DEPTH, 4, capture FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_in  in  1  reset, synchronous and active-high.
- con_1, con_2, con_3  inout  IO_DATA_WIDTH  shared buses to the chip.
- con_valid  out  1  host word-triplet valid toward the chip.
- con_ready  in  1  chip accepts the triplet.
- driving_cons  in  1  chip owns the buses.
- output_valid  in  1  chip output triplet present on the con buses.
- output_x / output_y / output_ch  in  clog2 widths  output tag.
- src_data  in  3*IO_DATA_WIDTH  upstream triplet, {con_3, con_2, con_1}.
- src_valid  in  1  upstream valid.
- src_ready  out  1  upstream ready.
- wr_data  out  3*IO_DATA_WIDTH  captured triplet.
- wr_x, wr_y, wr_ch  out  clog2 widths  captured tag.
- wr_valid  out  1  captured entry available.
- wr_ready  in  1  sink accepts the entry.
- overflow  out  1  sticky: an output was dropped because the FIFO was full.
- proto_err  out  1  sticky: output_valid was seen while driving_cons was 0.

## Operation
- **FSM states:** HOST_DRIVE (reset state), CHIP_DRIVE, TURNAROUND.
  - HOST_DRIVE → CHIP_DRIVE when driving_cons=1.
  - CHIP_DRIVE → TURNAROUND when driving_cons=0.
  - TURNAROUND → HOST_DRIVE unconditionally after 1 cycle.
- **Bus drive enable:** drive_en = (state==HOST_DRIVE) && !driving_cons && !rst_in.
  - When enabled, con_k carries holding-register word k.
  - Otherwise all three buses are 'Z.
- **Transmit holding register:** one entry, tx_full.
  - con_valid = tx_full && drive_en.
  - Transfer occurs when con_valid && con_ready; tx_full clears unless refilled in the same cycle.
  - src_ready = !rst_in && (!tx_full || transfer).
  - Load occurs when src_valid && src_ready.
  - Sustained throughput is 1 triplet per cycle.
- **Mid-beat ownership change:** if driving_cons rises while tx_full, the data is held and con_valid drops. con_valid re-asserts only after TURNAROUND completes.
- **Capture:** push when output_valid && driving_cons; the entry is {output_x, output_y, output_ch, con_3, con_2, con_1}.
  - Pop when wr_valid && wr_ready.
  - wr_valid = FIFO not empty; wr_* outputs show the head entry.
- **Full FIFO:**
  - Push while full and popping in the same cycle: accepted, count unchanged.
  - Push while full and not popping: entry dropped, overflow set.
- **proto_err:** set when output_valid && !driving_cons; the data is ignored.
- **Sticky flags:** overflow and proto_err clear only on reset.

## Timing
- **Reset values:** state=HOST_DRIVE, tx_full=0, con_valid=0, src_ready=0 during reset (1 on the first cycle after), FIFO empty, wr_valid=0, overflow=0, proto_err=0, buses 'Z.
- **Transmit latency:** src accept → con_valid is 1 cycle (registered holding).
- **Capture latency:** output_valid at edge n → wr_valid high after edge n when the FIFO was empty.
- **Turnaround:** at least 1 idle cycle, with buses 'Z and con_valid=0, between the chip releasing and the host driving.
- **Host release:** combinational on driving_cons, the same cycle the chip drives.
- **Reset mid-operation:** flushes the holding register and FIFO, clears flags, forces HOST_DRIVE. In-flight data is discarded.
- **Pointer width:** FIFO pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.

## Configuration
- **CON_HOST_PORT_STATS_EN defined:** adds outputs tx_beats and rx_beats, each 32 bits.
  - tx_beats counts con transfers.
  - rx_beats counts accepted pushes.
  - Both reset to 0 and wrap at 2^32.
- **Not defined:** the ports and counters are absent; all other behaviour is identical.

## Test plan
- **Back-to-back transmit:** src_valid held high with triplets 0x0001/0x0002/0x0003 and 0x0004/0x0005/0x0006, con_ready=1 → con_valid is high for 2 consecutive cycles starting 1 cycle after the first accept, with matching con values; src_ready stays 1.
- **Backpressure:** con_ready=0 for 3 cycles with tx_full → con values stable and src_ready=0; the triplet transfers on the cycle con_ready=1.
- **Ownership change:** driving_cons rises with tx_full → buses 'Z the same cycle and con_valid=0. driving_cons falls → exactly 1 TURNAROUND cycle, then con_valid=1 with the original data.
- **Capture:** 3 output_valid beats (x=5, y=7, ch=2 with data 0xAAAA/0xBBBB/0xCCCC, and so on) with wr_ready=1 → 3 wr beats in order, each 1 cycle after its input.
- **Overflow and protocol error:** wr_ready=0 and 5 pushes with FIFO_DEPTH=4 → the first 4 are retained and overflow=1 sticky. A separate output_valid with driving_cons=0 → proto_err=1 and no push.
- **Reset mid-stream:** rst_in pulsed for 1 cycle with the FIFO holding 2 entries and tx_full=1 → wr_valid=0, con_valid=0, flags 0, state HOST_DRIVE. With CON_HOST_PORT_STATS_EN, the counters also read 0.

Source files
------------

// File: rtl/con_host_port_if.sv
// Handshake and sideband bundle between con_host_port (master) and its system/chip-side peers (slave).
interface con_host_port_if #(
  parameter int DW = 16,
  parameter int XW = 10,
  parameter int YW = 10,
  parameter int CW = 6
);
  logic          con_valid, con_ready, driving_cons;
  logic          output_valid;
  logic [XW-1:0] output_x;
  logic [YW-1:0] output_y;
  logic [CW-1:0] output_ch;
  logic [3*DW-1:0] src_data;
  logic          src_valid, src_ready;
  logic [3*DW-1:0] wr_data;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic [CW-1:0] wr_ch;
  logic          wr_valid, wr_ready;
  logic          overflow, proto_err;

  modport master (
    output con_valid, src_ready, wr_data, wr_x, wr_y, wr_ch, wr_valid, overflow, proto_err,
    input  con_ready, driving_cons, output_valid, output_x, output_y, output_ch,
           src_data, src_valid, wr_ready
  );
  modport slave (
    input  con_valid, src_ready, wr_data, wr_x, wr_y, wr_ch, wr_valid, overflow, proto_err,
    output con_ready, driving_cons, output_valid, output_x, output_y, output_ch,
           src_data, src_valid, wr_ready
  );
endinterface

// File: rtl/con_host_port.sv
// Host side of the three-bus con link: transmit holding register, bus turnaround FSM, capture FIFO.
// Optional CON_HOST_PORT_STATS_EN adds 32-bit tx_beats/rx_beats counters.
module con_host_port #(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic clk,
  input  logic rst_in,
  inout  wire  [IO_DATA_WIDTH-1:0] con_1,
  inout  wire  [IO_DATA_WIDTH-1:0] con_2,
  inout  wire  [IO_DATA_WIDTH-1:0] con_3,
  con_host_port_if.master bus
`ifdef CON_HOST_PORT_STATS_EN
  ,
  output logic [31:0] tx_beats,
  output logic [31:0] rx_beats
`endif
);
  localparam int DW = IO_DATA_WIDTH;
  localparam int XW = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CW = $clog2(OUTPUT_NB_CHANNELS);
  localparam int EW = XW + YW + CW + 3*DW;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {HOST_DRIVE, CHIP_DRIVE, TURNAROUND} state_e;

  state_e          state_q;
  logic            tx_full_q, tx_full_d;
  logic [3*DW-1:0] tx_q;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [PW:0]     cnt_q, cnt_d;
  logic            overflow_q, proto_err_q;

  logic drive_en, transfer, load, push_req, push, pop, full;
  logic [EW-1:0] entry, head;

  // Host releases the buses combinationally the moment the chip claims them.
  assign drive_en = (state_q == HOST_DRIVE) && !bus.driving_cons && !rst_in;
  assign con_1 = drive_en ? tx_q[DW-1:0]      : {DW{1'bz}};
  assign con_2 = drive_en ? tx_q[2*DW-1:DW]   : {DW{1'bz}};
  assign con_3 = drive_en ? tx_q[3*DW-1:2*DW] : {DW{1'bz}};

  assign bus.con_valid = tx_full_q && drive_en;
  assign transfer      = bus.con_valid && bus.con_ready;
  assign bus.src_ready = !rst_in && (!tx_full_q || transfer);
  assign load          = bus.src_valid && bus.src_ready;

  always_comb begin
    tx_full_d = tx_full_q;
    if (load)          tx_full_d = 1'b1;
    else if (transfer) tx_full_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q   <= HOST_DRIVE;
      tx_full_q <= 1'b0;
    end else begin
      tx_full_q <= tx_full_d;
      case (state_q)
        HOST_DRIVE: if (bus.driving_cons)  state_q <= CHIP_DRIVE;
        CHIP_DRIVE: if (!bus.driving_cons) state_q <= TURNAROUND;
        default:                           state_q <= HOST_DRIVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (load) tx_q <= bus.src_data;
  end

  // Capture FIFO; a push into a full FIFO survives only if the head leaves the same cycle.
  assign entry    = {bus.output_x, bus.output_y, bus.output_ch, con_3, con_2, con_1};
  assign full     = (cnt_q == DEPTH_C);
  assign pop      = bus.wr_valid && bus.wr_ready;
  assign push_req = bus.output_valid && bus.driving_cons;
  assign push     = push_req && (!full || pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      if (push_req && full && !pop)                 overflow_q  <= 1'b1;
      if (bus.output_valid && !bus.driving_cons)    proto_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= entry;
  end

  assign head          = mem_q[rptr_q];
  assign bus.wr_valid  = (cnt_q != '0);
  assign bus.wr_data   = head[3*DW-1:0];
  assign bus.wr_ch     = head[3*DW +: CW];
  assign bus.wr_y      = head[3*DW+CW +: YW];
  assign bus.wr_x      = head[3*DW+CW+YW +: XW];
  assign bus.overflow  = overflow_q;
  assign bus.proto_err = proto_err_q;

`ifdef CON_HOST_PORT_STATS_EN
  logic [31:0] tx_beats_q, rx_beats_q;
  always_ff @(posedge clk) begin
    if (rst_in) begin
      tx_beats_q <= '0;
      rx_beats_q <= '0;
    end else begin
      if (transfer) tx_beats_q <= tx_beats_q + 32'd1;
      if (push)     rx_beats_q <= rx_beats_q + 32'd1;
    end
  end
  assign tx_beats = tx_beats_q;
  assign rx_beats = rx_beats_q;
`endif
endmodule

// File: tb/tb_con_host_port.sv
// Scoreboard bench for con_host_port: stimulus queues expected beats, negedge monitors pop and compare.
module tb_con_host_port;
  logic clk = 1'b0;
  logic rst_in;
  always #5 clk = ~clk;

  con_host_port_if #(.DW(16), .XW(10), .YW(10), .CW(6)) bus ();

  wire  [15:0] con_1, con_2, con_3;
  logic [15:0] chip_d1, chip_d2, chip_d3;
  assign con_1 = bus.driving_cons ? chip_d1 : 16'hzzzz;
  assign con_2 = bus.driving_cons ? chip_d2 : 16'hzzzz;
  assign con_3 = bus.driving_cons ? chip_d3 : 16'hzzzz;

`ifdef CON_HOST_PORT_STATS_EN
  logic [31:0] tx_beats, rx_beats;
`endif

  con_host_port #(.IO_DATA_WIDTH(16), .FEATURE_MAP_WIDTH(1024), .FEATURE_MAP_HEIGHT(1024),
                  .OUTPUT_NB_CHANNELS(64), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_in(rst_in), .con_1(con_1), .con_2(con_2), .con_3(con_3), .bus(bus)
`ifdef CON_HOST_PORT_STATS_EN
    , .tx_beats(tx_beats), .rx_beats(rx_beats)
`endif
  );

  typedef struct {
    logic [47:0] d;
    logic [9:0]  x, y;
    logic [5:0]  ch;
  } wr_t;

  logic [47:0] txq[$];
  wr_t         wrq[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [9:0] x, y, input logic [5:0] ch,
                      input logic [15:0] d1, d2, d3, input bit expect_it);
    bus.output_valid = 1'b1;
    bus.output_x = x; bus.output_y = y; bus.output_ch = ch;
    chip_d1 = d1; chip_d2 = d2; chip_d3 = d3;
    if (expect_it) wrq.push_back('{d: {d3, d2, d1}, x: x, y: y, ch: ch});
  endtask

  // Transmit monitor
  always @(negedge clk) begin
    if (bus.con_valid && bus.con_ready) begin
      if (txq.size() == 0) chk("tx_unexpected", {16'h0, con_3, con_2, con_1}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("tx_data", {16'h0, con_3, con_2, con_1}, {16'h0, txq.pop_front()});
    end
  end

  // Capture monitor
  always @(negedge clk) begin
    if (bus.wr_valid && bus.wr_ready) begin
      if (wrq.size() == 0) chk("wr_unexpected", {16'h0, bus.wr_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        wr_t e;
        e = wrq.pop_front();
        chk("wr_data", {16'h0, bus.wr_data}, {16'h0, e.d});
        chk("wr_tag", {38'h0, bus.wr_x, bus.wr_y, bus.wr_ch}, {38'h0, e.x, e.y, e.ch});
      end
    end
  end

  initial begin
    rst_in = 1'b1;
    bus.con_ready = 0; bus.driving_cons = 0; bus.output_valid = 0;
    bus.output_x = 0; bus.output_y = 0; bus.output_ch = 0;
    bus.src_data = 0; bus.src_valid = 0; bus.wr_ready = 0;
    chip_d1 = 0; chip_d2 = 0; chip_d3 = 0;
    repeat (3) tick();
    chk("rst_con_valid", 64'(bus.con_valid), 0);
    chk("rst_src_ready", 64'(bus.src_ready), 0);
    chk("rst_wr_valid", 64'(bus.wr_valid), 0);
    chk("rst_overflow", 64'(bus.overflow), 0);
    chk("rst_proto_err", 64'(bus.proto_err), 0);
`ifdef CON_HOST_PORT_STATS_EN
    chk("rst_tx_beats", 64'(tx_beats), 0);
    chk("rst_rx_beats", 64'(rx_beats), 0);
`endif
    rst_in = 1'b0; #1;
    chk("post_rst_src_ready", 64'(bus.src_ready), 1);

    // Back-to-back transmit
    bus.con_ready = 1; bus.src_valid = 1;
    bus.src_data = 48'h0003_0002_0001; txq.push_back(bus.src_data);
    tick();
    chk("b2b_cv0", 64'(bus.con_valid), 1);
    chk("b2b_sr0", 64'(bus.src_ready), 1);
    bus.src_data = 48'h0006_0005_0004; txq.push_back(bus.src_data);
    tick();
    chk("b2b_cv1", 64'(bus.con_valid), 1);
    chk("b2b_sr1", 64'(bus.src_ready), 1);
    bus.src_valid = 0;
    tick();
    chk("b2b_cv_end", 64'(bus.con_valid), 0);

    // Backpressure
    bus.con_ready = 0; bus.src_valid = 1;
    bus.src_data = 48'h0009_0008_0007; txq.push_back(bus.src_data);
    tick();
    bus.src_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_cv", 64'(bus.con_valid), 1);
      chk("bp_sr", 64'(bus.src_ready), 0);
      chk("bp_bus", {16'h0, con_3, con_2, con_1}, 64'h0009_0008_0007);
      tick();
    end
    bus.con_ready = 1; #1;
    chk("bp_release_sr", 64'(bus.src_ready), 1);
    tick();
    chk("bp_cv_end", 64'(bus.con_valid), 0);

    // Ownership change with a full holding register
    bus.con_ready = 0; bus.src_valid = 1;
    bus.src_data = 48'h000C_000B_000A; txq.push_back(bus.src_data);
    tick();
    bus.src_valid = 0;
    chk("own_cv_pre", 64'(bus.con_valid), 1);
    bus.con_ready = 1; bus.driving_cons = 1;
    chip_d1 = 16'h1111; chip_d2 = 16'h2222; chip_d3 = 16'h3333; #1;
    chk("own_cv_release", 64'(bus.con_valid), 0);
    chk("own_bus_chip", {16'h0, con_3, con_2, con_1}, 64'h3333_2222_1111);
    tick();
    chk("own_cv_chip", 64'(bus.con_valid), 0);
    tick();
    bus.driving_cons = 0; #1;
    chk("own_cv_drop", 64'(bus.con_valid), 0);
    tick();
    chk("own_cv_turnaround", 64'(bus.con_valid), 0);
    tick();
    chk("own_cv_back", 64'(bus.con_valid), 1);
    chk("own_bus_back", {16'h0, con_3, con_2, con_1}, 64'h000C_000B_000A);
    tick();
    chk("own_cv_end", 64'(bus.con_valid), 0);

    // Capture with a free-flowing sink
    bus.driving_cons = 1; bus.wr_ready = 1;
    tick();
    beat(10'd5, 10'd7, 6'd2, 16'hAAAA, 16'hBBBB, 16'hCCCC, 1'b1); tick();
    chk("cap_lat0", 64'(bus.wr_valid), 1);
    beat(10'd6, 10'd8, 6'd3, 16'h1234, 16'h5678, 16'h9ABC, 1'b1); tick();
    chk("cap_lat1", 64'(bus.wr_valid), 1);
    beat(10'd7, 10'd9, 6'd4, 16'h0F0F, 16'hF0F0, 16'hFFFF, 1'b1); tick();
    chk("cap_lat2", 64'(bus.wr_valid), 1);
    bus.output_valid = 0;
    tick();
    chk("cap_drained", 64'(bus.wr_valid), 0);

    // Overflow: five pushes into a four-entry FIFO with the sink stalled
    bus.wr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      beat(10'(i), 10'(i + 1), 6'(i + 2), 16'(16'h0100 + i), 16'(16'h0200 + i), 16'(16'h0300 + i), i < 4);
      tick();
      if (i == 3) chk("ovf_not_yet", 64'(bus.overflow), 0);
    end
    bus.output_valid = 0;
    chk("ovf_set", 64'(bus.overflow), 1);
    chk("ovf_wr_valid", 64'(bus.wr_valid), 1);
    bus.wr_ready = 1;
    repeat (4) tick();
    chk("ovf_drained", 64'(bus.wr_valid), 0);
    chk("ovf_sticky", 64'(bus.overflow), 1);
    bus.wr_ready = 0;

    // Protocol error: output_valid while the host owns the buses
    bus.driving_cons = 0;
    tick();
    chk("perr_pre", 64'(bus.proto_err), 0);
    beat(10'd1, 10'd1, 6'd1, 16'hDEAD, 16'hBEEF, 16'hCAFE, 1'b0);
    tick();
    bus.output_valid = 0;
    chk("perr_set", 64'(bus.proto_err), 1);
    chk("perr_no_push", 64'(bus.wr_valid), 0);
    tick();
    chk("perr_sticky", 64'(bus.proto_err), 1);
`ifdef CON_HOST_PORT_STATS_EN
    chk("stats_tx", 64'(tx_beats), 4);
    chk("stats_rx", 64'(rx_beats), 7);
`endif

    // Reset mid-stream: two FIFO entries and a loaded holding register are discarded
    bus.driving_cons = 1; bus.con_ready = 0;
    tick();
    beat(10'd2, 10'd2, 6'd2, 16'h5555, 16'h6666, 16'h7777, 1'b0);
    bus.src_valid = 1; bus.src_data = 48'hEEEE_DDDD_CCCC;
    tick();
    bus.src_valid = 0;
    tick();
    bus.output_valid = 0;
    chk("mid_pre_wr_valid", 64'(bus.wr_valid), 1);
    bus.driving_cons = 0; rst_in = 1;
    tick();
    rst_in = 0; #1;
    chk("mid_wr_valid", 64'(bus.wr_valid), 0);
    chk("mid_con_valid", 64'(bus.con_valid), 0);
    chk("mid_overflow", 64'(bus.overflow), 0);
    chk("mid_proto_err", 64'(bus.proto_err), 0);
    chk("mid_src_ready", 64'(bus.src_ready), 1);
`ifdef CON_HOST_PORT_STATS_EN
    chk("mid_tx_beats", 64'(tx_beats), 0);
    chk("mid_rx_beats", 64'(rx_beats), 0);
`endif
    bus.con_ready = 1; bus.src_valid = 1;
    bus.src_data = 48'h0F03_0F02_0F01; txq.push_back(bus.src_data);
    tick();
    bus.src_valid = 0;
    chk("mid_host_drive", 64'(bus.con_valid), 1);
    tick();
    chk("mid_cv_end", 64'(bus.con_valid), 0);
`ifdef CON_HOST_PORT_STATS_EN
    chk("mid_tx_after", 64'(tx_beats), 1);
`endif

    chk("txq_empty", 64'(txq.size()), 0);
    chk("wrq_empty", 64'(wrq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
